// File: rtl/multicycle_control_fsm.sv
// Control unit for a multicycle RV32 datapath: sequences IF/ID/EX/MEM/WB/PC4/HALT
// and decodes datapath enables and mux selects from the current state and opcode.
module multicycle_control_fsm #(
    parameter bit ECALL_HALT = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       bcond,
    input  logic       halt_cond,
    output logic       pc_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       alu_src_a,
    output logic       pc_source,
    output logic [1:0] alu_src_b,
    output logic [1:0] mem_to_reg,
    output logic [1:0] alu_op,
    output logic       is_halted
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IARITH = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_4    = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_ALURES = 2'b10;
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_BR    = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_PC4  = 3'd5,
        S_HALT = 3'd6
    } state_e;

    state_e state_q, state_d;

    logic pc_write_c, ir_write_c, reg_write_c, mem_read_c, mem_write_c, halted_c;
    logic is_exec_op;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IF;
        else       state_q <= state_d;
    end

    always_comb begin
        is_exec_op = 1'b0;
        case (opcode)
            OP_R, OP_IARITH, OP_LOAD, OP_STORE,
            OP_BRANCH, OP_JAL, OP_JALR: is_exec_op = 1'b1;
            default:                    is_exec_op = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pc_write_c  = 1'b0;
        ir_write_c  = 1'b0;
        reg_write_c = 1'b0;
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;
        halted_c    = 1'b0;
        i_or_d      = 1'b0;
        alu_src_a   = 1'b0;
        pc_source   = 1'b0;
        alu_src_b   = SRCB_B;
        mem_to_reg  = WB_ALUOUT;
        alu_op      = ALU_ADD;

        case (state_q)
            S_IF: begin
                mem_read_c = 1'b1;
                ir_write_c = 1'b1;
                state_d    = S_ID;
            end

            S_ID: begin
                // ALUOut <= PC + imm, the branch/jump target, for every opcode
                alu_src_b = SRCB_IMM;
                if (is_exec_op)
                    state_d = S_EX;
                else if (opcode == OP_ECALL && halt_cond && ECALL_HALT)
                    state_d = S_HALT;
                else
                    state_d = S_PC4;
            end

            S_EX: begin
                case (opcode)
                    OP_R: begin
                        alu_src_a = 1'b1;
                        alu_src_b = SRCB_B;
                        alu_op    = ALU_FUNCT;
                        state_d   = S_WB;
                    end
                    OP_IARITH: begin
                        alu_src_a = 1'b1;
                        alu_src_b = SRCB_IMM;
                        alu_op    = ALU_FUNCT;
                        state_d   = S_WB;
                    end
                    OP_LOAD, OP_STORE, OP_JALR: begin
                        alu_src_a = 1'b1;
                        alu_src_b = SRCB_IMM;
                        state_d   = (opcode == OP_JALR) ? S_WB : S_MEM;
                    end
                    OP_BRANCH: begin
                        alu_src_a = 1'b1;
                        alu_op    = ALU_BR;
                        if (bcond) begin
                            pc_write_c = 1'b1;
                            pc_source  = 1'b1;
                            state_d    = S_IF;
                        end else begin
                            state_d    = S_PC4;
                        end
                    end
                    OP_JAL: begin
                        // rd <= PC+4 while PC <= ALUOut (target computed in ID)
                        reg_write_c = 1'b1;
                        mem_to_reg  = WB_ALURES;
                        alu_src_b   = SRCB_4;
                        pc_write_c  = 1'b1;
                        pc_source   = 1'b1;
                        state_d     = S_IF;
                    end
                    default: state_d = S_PC4;
                endcase
            end

            S_MEM: begin
                case (opcode)
                    OP_LOAD: begin
                        mem_read_c = 1'b1;
                        i_or_d     = 1'b1;
                        state_d    = S_WB;
                    end
                    OP_STORE: begin
                        mem_write_c = 1'b1;
                        i_or_d      = 1'b1;
                        alu_src_b   = SRCB_4;
                        pc_write_c  = 1'b1;
                        state_d     = S_IF;
                    end
                    default: state_d = S_IF;
                endcase
            end

            S_WB: begin
                case (opcode)
                    OP_R, OP_IARITH, OP_LOAD: begin
                        reg_write_c = 1'b1;
                        mem_to_reg  = (opcode == OP_LOAD) ? WB_MDR : WB_ALUOUT;
                        alu_src_b   = SRCB_4;
                        pc_write_c  = 1'b1;
                    end
                    OP_JALR: begin
                        // ALU still adds PC+4 for rd; PC takes the jump target from ALUOut
                        reg_write_c = 1'b1;
                        mem_to_reg  = WB_ALURES;
                        alu_src_b   = SRCB_4;
                        pc_write_c  = 1'b1;
                        pc_source   = 1'b1;
                    end
                    default: ;
                endcase
                state_d = S_IF;
            end

            S_PC4: begin
                alu_src_b  = SRCB_4;
                pc_write_c = 1'b1;
                state_d    = S_IF;
            end

            S_HALT: begin
                halted_c = 1'b1;
                state_d  = S_HALT;
            end

            default: state_d = S_IF;
        endcase
    end

    // Reset masks side effects combinationally so nothing commits in the reset cycle
    assign pc_write  = pc_write_c  & ~reset;
    assign ir_write  = ir_write_c  & ~reset;
    assign reg_write = reg_write_c & ~reset;
    assign mem_read  = mem_read_c  & ~reset;
    assign mem_write = mem_write_c & ~reset;
    assign is_halted = halted_c    & ~reset;

endmodule
